// File: rtl/run_control.sv
// run_control: synchronises and debounces KEY1, classifies short/long presses,
// runs the IDLE/RUN/PAUSE/DONE controller and keeps a two-digit BCD pass count.
module run_control #(
    parameter int DEBOUNCE_TICKS   = 2,
    parameter int LONG_PRESS_TICKS = 20,
    parameter int MAX_PASSES       = 10
) (
    input  logic       clk_01hz,
    input  logic       reset,
    input  logic       key_start_n,
    input  logic       mode_continuous,
    input  logic       seq_wrap,
    output logic       run,
    output logic       seq_clear,
    output logic       paused,
    output logic       done,
    output logic [3:0] pass_tens,
    output logic [3:0] pass_ones,
    output logic [1:0] state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [3:0] DB_LIMIT   = 4'(DEBOUNCE_TICKS);
    localparam logic [5:0] HOLD_LIMIT = 6'(LONG_PRESS_TICKS);
    localparam logic [3:0] MAX_TENS   = 4'(MAX_PASSES / 10);
    localparam logic [3:0] MAX_ONES   = 4'(MAX_PASSES % 10);

    logic       s1;
    logic       s2;
    logic       pressed;
    logic [3:0] db_cnt;
    logic [5:0] hold_cnt;
    logic       long_fired;
    logic       long_next;
    logic       long_evt;
    logic       short_evt;

    logic [3:0] inc_tens;
    logic [3:0] inc_ones;
    logic       inc_at_limit;

    // Long press is reported once per hold; long_fired masks the saturated count.
    assign long_next = pressed && (hold_cnt == HOLD_LIMIT) && !long_fired;

    // Key synchroniser, debounce, hold timer and press classification.
    always_ff @(posedge clk_01hz or posedge reset) begin
        if (reset) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            pressed    <= 1'b0;
            db_cnt     <= '0;
            hold_cnt   <= '0;
            long_fired <= 1'b0;
            long_evt   <= 1'b0;
            short_evt  <= 1'b0;
        end else begin
            s1 <= ~key_start_n;
            s2 <= s1;

            if (s2 != pressed) begin
                if (db_cnt + 4'd1 == DB_LIMIT) begin
                    pressed <= s2;
                    db_cnt  <= '0;
                end else begin
                    db_cnt <= db_cnt + 4'd1;
                end
            end else begin
                db_cnt <= '0;
            end

            if (!pressed)
                hold_cnt <= '0;
            else if (hold_cnt != HOLD_LIMIT)
                hold_cnt <= hold_cnt + 6'd1;

            long_evt   <= long_next;
            long_fired <= pressed && (long_fired || long_next);
            // A non-zero hold count with pressed low means pressed fell on the last edge.
            short_evt  <= !pressed && (hold_cnt != '0) && (hold_cnt < HOLD_LIMIT);
        end
    end

    // BCD increment of the pass count and single-shot limit compare.
    always_comb begin
        inc_tens = pass_tens;
        inc_ones = pass_ones + 4'd1;
        if (pass_ones == 4'd9) begin
            inc_ones = 4'd0;
            inc_tens = (pass_tens == 4'd9) ? 4'd0 : pass_tens + 4'd1;
        end
        inc_at_limit = (inc_tens == MAX_TENS) && (inc_ones == MAX_ONES);
    end

    // Run-control FSM, pass counter and one-tick sequencer clear.
    always_ff @(posedge clk_01hz or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            pass_tens <= '0;
            pass_ones <= '0;
            seq_clear <= 1'b0;
        end else begin
            seq_clear <= 1'b0;
            if (long_evt) begin
                state     <= ST_IDLE;
                pass_tens <= '0;
                pass_ones <= '0;
                seq_clear <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (short_evt) begin
                            state     <= ST_RUN;
                            pass_tens <= '0;
                            pass_ones <= '0;
                            seq_clear <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (seq_wrap) begin
                            pass_tens <= inc_tens;
                            pass_ones <= inc_ones;
                            // Reaching the limit outranks a coincident pause request.
                            if (!mode_continuous && inc_at_limit)
                                state <= ST_DONE;
                            else if (short_evt)
                                state <= ST_PAUSE;
                        end else if (short_evt) begin
                            state <= ST_PAUSE;
                        end
                    end
                    ST_PAUSE: begin
                        if (short_evt)
                            state <= ST_RUN;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign run    = (state == ST_RUN);
    assign paused = (state == ST_PAUSE);
    assign done   = (state == ST_DONE);

endmodule

// File: tb/tb_run_control.sv
// tb_run_control: directed test of run_control with hand-computed expectations.
module tb_run_control;

    logic       clk_01hz;
    logic       reset;
    logic       key_start_n;
    logic       mode_continuous;
    logic       seq_wrap;
    logic       run;
    logic       seq_clear;
    logic       paused;
    logic       done;
    logic [3:0] pass_tens;
    logic [3:0] pass_ones;
    logic [1:0] state;

    int checks;
    int errors;
    int clear_count;
    int c0;

    run_control #(
        .DEBOUNCE_TICKS(2),
        .LONG_PRESS_TICKS(20),
        .MAX_PASSES(10)
    ) dut (
        .clk_01hz(clk_01hz),
        .reset(reset),
        .key_start_n(key_start_n),
        .mode_continuous(mode_continuous),
        .seq_wrap(seq_wrap),
        .run(run),
        .seq_clear(seq_clear),
        .paused(paused),
        .done(done),
        .pass_tens(pass_tens),
        .pass_ones(pass_ones),
        .state(state)
    );

    initial clk_01hz = 1'b0;
    always #5 clk_01hz = ~clk_01hz;

    task automatic check_val(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // One clock edge; sample 1 time unit later and count observed clear pulses.
    task automatic tick();
        @(posedge clk_01hz);
        #1;
        if (seq_clear) clear_count++;
    endtask

    task automatic wrap();
        seq_wrap = 1'b1;
        tick();
        seq_wrap = 1'b0;
    endtask

    // Five-tick press, release, then five more ticks: the action lands on the next tick.
    task automatic do_short();
        key_start_n = 1'b0;
        repeat (5) tick();
        key_start_n = 1'b1;
        repeat (5) tick();
    endtask

    function automatic int cnt();
        return {24'd0, pass_tens, pass_ones};
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        clear_count = 0;
        reset = 1'b1;
        key_start_n = 1'b1;
        mode_continuous = 1'b0;
        seq_wrap = 1'b0;
        repeat (3) tick();

        check_val("rst_state", state, 0);
        check_val("rst_run", run, 0);
        check_val("rst_paused", paused, 0);
        check_val("rst_done", done, 0);
        check_val("rst_clear", seq_clear, 0);
        check_val("rst_count", cnt(), 'h00);
        reset = 1'b0;
        repeat (2) tick();

        // Short press from IDLE starts the sequencer
        c0 = clear_count;
        do_short();
        check_val("press_latency", state, 0);
        tick();
        check_val("start_state", state, 1);
        check_val("start_run", run, 1);
        check_val("start_clear", seq_clear, 1);
        check_val("start_count", cnt(), 'h00);
        tick();
        check_val("start_clear_end", seq_clear, 0);
        check_val("start_clear_pulses", clear_count - c0, 1);

        // Single-shot: stop after ten passes
        repeat (9) wrap();
        check_val("ss_count9", cnt(), 'h09);
        check_val("ss_run9", run, 1);
        wrap();
        check_val("ss_count10", cnt(), 'h10);
        check_val("ss_done", done, 1);
        check_val("ss_run_off", run, 0);
        check_val("ss_state", state, 3);
        wrap();
        check_val("ss_count11", cnt(), 'h10);
        check_val("ss_state11", state, 3);

        // Continuous: restart from DONE, wrap 99 -> 00
        mode_continuous = 1'b1;
        do_short();
        tick();
        check_val("cont_state", state, 1);
        check_val("cont_count0", cnt(), 'h00);
        check_val("cont_clear", seq_clear, 1);
        for (int i = 1; i <= 100; i++) begin
            wrap();
            if (i == 10) check_val("cont_count10", cnt(), 'h10);
            if (i == 99) check_val("cont_count99", cnt(), 'h99);
            if (i == 100) begin
                check_val("cont_count100", cnt(), 'h00);
                check_val("cont_run", run, 1);
            end
        end

        // Pause ignores wraps; resume keeps count with no clear
        repeat (3) wrap();
        check_val("pre_pause_count", cnt(), 'h03);
        c0 = clear_count;
        do_short();
        tick();
        check_val("pause_state", state, 2);
        check_val("pause_flag", paused, 1);
        check_val("pause_run", run, 0);
        repeat (3) wrap();
        check_val("pause_count", cnt(), 'h03);
        check_val("pause_state_hold", state, 2);
        do_short();
        tick();
        check_val("resume_state", state, 1);
        check_val("resume_run", run, 1);
        check_val("resume_count", cnt(), 'h03);
        check_val("resume_no_clear", clear_count - c0, 0);

        // Long hold from RUN returns to IDLE
        repeat (4) wrap();
        check_val("pre_long_count", cnt(), 'h07);
        c0 = clear_count;
        key_start_n = 1'b0;
        repeat (25) tick();
        key_start_n = 1'b1;
        check_val("long_pre_state", state, 1);
        tick();
        check_val("long_state", state, 0);
        check_val("long_count", cnt(), 'h00);
        check_val("long_clear", seq_clear, 1);
        repeat (10) tick();
        check_val("long_release_state", state, 0);
        check_val("long_clear_pulses", clear_count - c0, 1);

        // One-tick glitch produces nothing
        key_start_n = 1'b0;
        tick();
        key_start_n = 1'b1;
        repeat (8) tick();
        check_val("glitch_state", state, 0);
        check_val("glitch_clear_pulses", clear_count - c0, 1);

        // Release coinciding with the 10th single-shot wrap: DONE wins
        mode_continuous = 1'b0;
        do_short();
        tick();
        check_val("ss2_state", state, 1);
        repeat (9) wrap();
        check_val("ss2_count9", cnt(), 'h09);
        do_short();
        wrap();
        check_val("coinc_state", state, 3);
        check_val("coinc_count", cnt(), 'h10);
        check_val("coinc_done", done, 1);

        // Asynchronous reset mid-RUN with the key held
        do_short();
        tick();
        check_val("rr_state", state, 1);
        repeat (2) wrap();
        check_val("rr_count", cnt(), 'h02);
        key_start_n = 1'b0;
        repeat (3) tick();
        #2;
        reset = 1'b1;
        #1;
        check_val("arst_state", state, 0);
        check_val("arst_run", run, 0);
        check_val("arst_paused", paused, 0);
        check_val("arst_done", done, 0);
        check_val("arst_clear", seq_clear, 0);
        check_val("arst_count", cnt(), 'h00);
        key_start_n = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (10) tick();
        check_val("post_rst_state", state, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/run_control.md
# run_control

Front-end run controller for the LED pattern sequencer, clocked by the 0.1 s tick. It synchronises and debounces the raw KEY1 start button, classifies presses as short or long, and drives run/restart control into the pattern stage. It also counts completed sequence passes in two-digit BCD for the 7-segment decoder. In single-shot mode it halts the sequencer after a programmed number of passes.

## Interface
- DEBOUNCE_TICKS, 2, consecutive identical synchronised samples needed to change debounced key level (1..15)
- LONG_PRESS_TICKS, 20, ticks held to qualify as long press (2 s; 2..63)
- MAX_PASSES, 10, pass limit in single-shot mode (1..99)

- clk_01hz  in  1  0.1 s tick clock; all state on rising edge
- reset  in  1  asynchronous, active-high
- key_start_n  in  1  raw KEY1, active-low, asynchronous to clk_01hz
- mode_continuous  in  1  1 = repeat forever, 0 = stop after MAX_PASSES
- seq_wrap  in  1  one-tick pulse from sequencer when its step wraps to 0
- run  out  1  sequencer enable
- seq_clear  out  1  one-tick pulse: sequencer restarts at step 0
- paused  out  1  high in PAUSE
- done  out  1  high in DONE
- pass_tens  out  4  BCD tens of pass count
- pass_ones  out  4  BCD ones of pass count
- state  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3

## Operation
- Sync: two flops on ~key_start_n (pressed = 1), both reset to 0.
- Debounce: counter increments each edge that s2 differs from `pressed`, cleared when equal. `pressed` toggles on the edge the counter would reach DEBOUNCE_TICKS.
- Hold counter: 0 while pressed=0; increments each edge pressed=1, saturates at LONG_PRESS_TICKS.
- long_evt (registered): asserted on the edge the hold counter becomes LONG_PRESS_TICKS. Fires exactly once per hold.
- short_evt (registered): asserted on the edge `pressed` falls with hold counter < LONG_PRESS_TICKS. Release after a long press produces no event.
- FSM acts on the registered events one edge later:
  - long_evt, any state -> IDLE: count := 00, seq_clear pulse.
  - short_evt: IDLE -> RUN (count := 00, seq_clear); RUN -> PAUSE; PAUSE -> RUN (count kept, no seq_clear); DONE -> RUN (count := 00, seq_clear).
  - seq_wrap only in RUN: BCD increment (ones 9 -> 0 carries to tens). Continuous mode wraps 99 -> 00. Single-shot: if new count == MAX_PASSES -> DONE.
- Simultaneous events on the same edge:
  - seq_wrap + short_evt in RUN: increment first, then PAUSE, unless the limit is reached, in which case DONE wins.
  - long_evt + seq_wrap: long_evt wins, count 00.
- mode_continuous change while count ≥ MAX_PASSES: no immediate DONE; compare only on the next increment (equality). Continuous wrap still applies.
- run = (state==RUN); paused, done are decodes of state.
- All BCD digits stay in 0..9 at all times.

## Timing
- Reset values: state IDLE, run 0, paused 0, done 0, seq_clear 0, pass_tens/ones 0, sync/debounce/hold counters 0, pressed 0.
- Reset is async assert; takes effect mid-operation immediately, including mid-debounce or mid-hold.
- Press latency (DEBOUNCE_TICKS=2): key low before edge 0 -> s2 at edge 1 -> pressed at edge 3.
- Short action: short_evt at the edge after pressed falls; state/run change one edge later. Release before edge R -> run change at edge R+5.
- Long action: hold counter hits 20 at the 20th pressed edge; state IDLE two edges later.
- seq_clear is high for exactly one tick. seq_wrap is sampled and counted on the same edge.

## Test plan
- Reset, hold key 5 ticks, release -> run=1, seq_clear one-tick pulse, count 00, state=1.
- mode_continuous=0, in RUN, 10 seq_wrap pulses -> tens=1, ones=0, done=1, run=0; an 11th wrap leaves count 10.
- mode_continuous=1, 100 wraps -> count 99 after 99th, 00 after 100th; run stays 1.
- Short press in RUN -> paused=1; 3 wraps ignored; short press -> run=1, count unchanged, no seq_clear.
- Hold key 25 ticks from RUN with count 07 -> IDLE, count 00, one seq_clear; release gives no further action. A 1-tick key glitch gives no event.
- Short-press release coinciding with the 10th wrap in single-shot -> DONE, count 10; assert reset mid-RUN -> all outputs at reset values immediately.
